// File: rtl/game_pkg.sv
// Shared game constants: status codes, tile/board widths, solved board.
// Used by the game sequencer, board selector and display logic.
package game_pkg;

  localparam int TILE_W  = 3;
  localparam int N_TILES = 4;
  localparam int BOARD_W = TILE_W * N_TILES;

  localparam logic [1:0] CHOSE_BOARD  = 2'b00;
  localparam logic [1:0] GAMING       = 2'b01;
  localparam logic [1:0] GAME_INITIAL = 2'b10;
  localparam logic [1:0] WINNED       = 2'b11;

  localparam logic [BOARD_W-1:0] SOLVED =
    12'b000_001_010_011;

  typedef enum logic [1:0] {
    S_CHOSE = CHOSE_BOARD,
    S_PLAY  = GAMING,
    S_INIT  = GAME_INITIAL,
    S_WIN   = WINNED
  } state_e;

endpackage

// File: rtl/game_ctrl_if.sv
// Player/selector bundle of the game sequencer.
// master: player + selector side; slave: game_ctrl.
interface game_ctrl_if
  import game_pkg::*;
#(
  parameter int CNT_W = 8
);
  logic               confirm;
  logic               random_sel;
  logic [BOARD_W-1:0] board_in;
  logic               move_valid;
  logic [1:0]         move_pos;
  logic               restart;
  logic [1:0]         game_status;
  logic               set_o;
  logic               random_o;
  logic [BOARD_W-1:0] work_board;
  logic [CNT_W-1:0]   move_cnt;
  logic               lost_o;

  modport master (
    output confirm, random_sel, board_in,
    output move_valid, move_pos, restart,
    input  game_status, set_o, random_o,
    input  work_board, move_cnt, lost_o
  );

  modport slave (
    input  confirm, random_sel, board_in,
    input  move_valid, move_pos, restart,
    output game_status, set_o, random_o,
    output work_board, move_cnt, lost_o
  );

endinterface

// File: rtl/game_ctrl_board_swap.sv
// Swaps tile[pos] with tile[pos+1]; tile0 sits in the MSBs.
// Ports: board/pos in; swapped board and legal (pos<=2) out.
module board_swap
  import game_pkg::*;
(
  input  logic [BOARD_W-1:0] board,
  input  logic [1:0]         pos,
  output logic [BOARD_W-1:0] swapped,
  output logic               legal
);

  logic [TILE_W-1:0] t0, t1, t2, t3;

  assign {t0, t1, t2, t3} = board;
  assign legal = (pos != 2'd3);

  always_comb begin
    swapped = board;
    unique case (pos)
      2'd0:    swapped = {t1, t0, t2, t3};
      2'd1:    swapped = {t0, t2, t1, t3};
      2'd2:    swapped = {t0, t1, t3, t2};
      default: swapped = board;
    endcase
  end

endmodule

// File: rtl/game_ctrl.sv
// 4-tile puzzle sequencer: board load, swap moves, win detection.
// Ports: clk_d, rst (async high), bus (game_ctrl_if.slave).
// Optional GAME_MOVE_LIMIT_EN: MAX_MOVES limit with lost_o pulse.
module game_ctrl
  import game_pkg::*;
#(
  parameter int CNT_W = 8
`ifdef GAME_MOVE_LIMIT_EN
  , parameter int MAX_MOVES = 20
`endif
) (
  input  logic       clk_d,
  input  logic       rst,
  game_ctrl_if.slave bus
);

  state_e             state_q, state_d;
  logic [BOARD_W-1:0] work_q, work_d;
  logic [BOARD_W-1:0] orig_q, orig_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               lost_q, lost_d;
  // GAME_INITIAL entered from GAMING reloads
  // the stored original board.
  logic               reload_q, reload_d;

  logic [BOARD_W-1:0] swap_board;
  logic               swap_legal;
  logic [CNT_W-1:0]   cnt_inc;
  logic [BOARD_W-1:0] load_board;

  board_swap u_swap (
    .board   (work_q),
    .pos     (bus.move_pos),
    .swapped (swap_board),
    .legal   (swap_legal)
  );

  assign cnt_inc = (cnt_q == '1) ? cnt_q
                 : cnt_q + 1'b1;
  assign load_board = reload_q ? orig_q
                    : bus.board_in;

  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    orig_d   = orig_q;
    cnt_d    = cnt_q;
    lost_d   = 1'b0;
    reload_d = 1'b0;
    unique case (state_q)
      S_CHOSE: begin
        if (bus.confirm) state_d = S_INIT;
      end
      S_INIT: begin
        work_d  = load_board;
        orig_d  = load_board;
        cnt_d   = '0;
        state_d = (load_board == SOLVED)
                ? S_WIN : S_PLAY;
      end
      S_PLAY: begin
        if (bus.restart) begin
          state_d  = S_INIT;
          reload_d = 1'b1;
        end else if (bus.move_valid && swap_legal) begin
          work_d = swap_board;
          cnt_d  = cnt_inc;
          if (swap_board == SOLVED) begin
            state_d = S_WIN;
          end
`ifdef GAME_MOVE_LIMIT_EN
          else if (cnt_inc == CNT_W'(MAX_MOVES)) begin
            state_d  = S_INIT;
            reload_d = 1'b1;
            lost_d   = 1'b1;
          end
`endif
        end
      end
      S_WIN: begin
        if (bus.confirm) state_d = S_CHOSE;
      end
      default: state_d = S_CHOSE;
    endcase
  end

  always_ff @(posedge clk_d or posedge rst) begin
    if (rst) begin
      state_q  <= S_CHOSE;
      work_q   <= SOLVED;
      orig_q   <= SOLVED;
      cnt_q    <= '0;
      lost_q   <= 1'b0;
      reload_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      orig_q   <= orig_d;
      cnt_q    <= cnt_d;
      lost_q   <= lost_d;
      reload_q <= reload_d;
    end
  end

  assign bus.game_status = state_q;
  assign bus.work_board  = work_q;
  assign bus.move_cnt    = cnt_q;
  assign bus.lost_o      = lost_q;
  assign bus.set_o       = (state_q == S_CHOSE)
                         & bus.confirm;
  assign bus.random_o    = bus.random_sel;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl.
// Checks load, moves, win, restart, reset and move limit.
module tb_game_ctrl;
  import game_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  game_ctrl_if #(.CNT_W(8)) gif ();

`ifdef GAME_MOVE_LIMIT_EN
  game_ctrl #(.CNT_W(8), .MAX_MOVES(2)) dut (
`else
  game_ctrl #(.CNT_W(8)) dut (
`endif
    .clk_d (clk),
    .rst   (rst),
    .bus   (gif)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag,
                        input logic [1:0] st,
                        input logic [11:0] brd,
                        input logic [7:0] cnt);
    chk({tag, ".st"}, 16'(gif.game_status), 16'(st));
    chk({tag, ".brd"}, 16'(gif.work_board), 16'(brd));
    chk({tag, ".cnt"}, 16'(gif.move_cnt), 16'(cnt));
  endtask

  localparam logic [11:0] B1023 = 12'b001_000_010_011;
  localparam logic [11:0] B2130 = 12'b010_001_011_000;
  localparam logic [11:0] B2310 = 12'b010_011_001_000;
  localparam logic [11:0] B3210 = 12'b011_010_001_000;

  initial begin
    rst            = 1'b1;
    gif.confirm    = 1'b0;
    gif.random_sel = 1'b0;
    gif.board_in   = '0;
    gif.move_valid = 1'b0;
    gif.move_pos   = 2'd0;
    gif.restart    = 1'b0;
    tick();
    tick();
    chk_st("reset", CHOSE_BOARD, SOLVED, 8'd0);
    chk("reset.lost", 16'(gif.lost_o), 16'd0);
    rst = 1'b0;
    tick();

    // load 1023 as numbered board
    gif.board_in = B1023;
    gif.confirm  = 1'b1;
    #1;
    chk("t1.set", 16'(gif.set_o), 16'd1);
    chk("t1.rnd", 16'(gif.random_o), 16'd0);
    tick();
    gif.confirm = 1'b0;
    chk("t1.init", 16'(gif.game_status), 16'(GAME_INITIAL));
    chk("t1.set0", 16'(gif.set_o), 16'd0);
    tick();
    chk_st("t1.play", GAMING, B1023, 8'd0);

    // winning move on the same edge
    gif.move_valid = 1'b1;
    gif.move_pos   = 2'd0;
    tick();
    chk_st("t2.win", WINNED, SOLVED, 8'd1);
    // moves and restart ignored in WINNED
    gif.move_pos = 2'd1;
    gif.restart  = 1'b1;
    tick();
    gif.move_valid = 1'b0;
    gif.restart    = 1'b0;
    chk_st("t2.hold", WINNED, SOLVED, 8'd1);
    gif.confirm = 1'b1;
    #1;
    chk("t2.set", 16'(gif.set_o), 16'd0);
    tick();
    gif.confirm = 1'b0;
    chk("t2.back", 16'(gif.game_status), 16'(CHOSE_BOARD));

    // random board 2130, illegal + legal move, restart
    gif.random_sel = 1'b1;
    gif.board_in   = B2130;
    gif.confirm    = 1'b1;
    #1;
    chk("t3.rnd", 16'(gif.random_o), 16'd1);
    chk("t3.set", 16'(gif.set_o), 16'd1);
    tick();
    gif.confirm = 1'b0;
    tick();
    chk_st("t3.play", GAMING, B2130, 8'd0);
    gif.move_valid = 1'b1;
    gif.move_pos   = 2'd3;
    tick();
    chk_st("t3.ill", GAMING, B2130, 8'd0);
    gif.move_pos = 2'd1;
    tick();
    chk_st("t3.mv1", GAMING, B2310, 8'd1);
    gif.move_pos = 2'd0;
    gif.restart  = 1'b1;
    tick();
    gif.move_valid = 1'b0;
    gif.restart    = 1'b0;
    chk("t3.rs.st", 16'(gif.game_status), 16'(GAME_INITIAL));
    chk("t3.rs.brd", 16'(gif.work_board), 16'(B2310));
    tick();
    chk_st("t3.reload", GAMING, B2130, 8'd0);
    // confirm ignored in GAMING
    gif.confirm = 1'b1;
    #1;
    chk("t3.cset", 16'(gif.set_o), 16'd0);
    tick();
    gif.confirm = 1'b0;
    chk_st("t3.cign", GAMING, B2130, 8'd0);

    // async reset with a move in flight
    gif.move_valid = 1'b1;
    gif.move_pos   = 2'd0;
    #2;
    rst = 1'b1;
    #1;
    chk_st("t4.rst", CHOSE_BOARD, SOLVED, 8'd0);
    gif.move_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk_st("t4.after", CHOSE_BOARD, SOLVED, 8'd0);

    // move limit from 3210
    gif.random_sel = 1'b0;
    gif.board_in   = B3210;
    gif.confirm    = 1'b1;
    tick();
    gif.confirm = 1'b0;
    tick();
    chk_st("t5.play", GAMING, B3210, 8'd0);
    gif.move_valid = 1'b1;
    gif.move_pos   = 2'd0;
    tick();
    chk_st("t5.mv1", GAMING, B2310, 8'd1);
    tick();
    gif.move_valid = 1'b0;
`ifdef GAME_MOVE_LIMIT_EN
    chk("t5.lost", 16'(gif.lost_o), 16'd1);
    chk("t5.st", 16'(gif.game_status), 16'(GAME_INITIAL));
    tick();
    chk("t5.lost0", 16'(gif.lost_o), 16'd0);
    chk_st("t5.reload", GAMING, B3210, 8'd0);
`else
    chk("t5.lost", 16'(gif.lost_o), 16'd0);
    chk_st("t5.mv2", GAMING, B3210, 8'd2);
    tick();
    chk("t5.lost0", 16'(gif.lost_o), 16'd0);
`endif

    // solved board goes straight to WINNED
    rst = 1'b1;
    tick();
    rst = 1'b0;
    gif.board_in = SOLVED;
    gif.confirm  = 1'b1;
    tick();
    gif.confirm = 1'b0;
    chk("t6.init", 16'(gif.game_status), 16'(GAME_INITIAL));
    tick();
    chk_st("t6.win", WINNED, SOLVED, 8'd0);
    gif.move_valid = 1'b1;
    gif.move_pos   = 2'd2;
    tick();
    gif.move_valid = 1'b0;
    chk_st("t6.hold", WINNED, SOLVED, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
